// File: rtl/pe_dbuf.sv
`default_nettype none
// ============================================================================
// Module   : pe_dbuf
// Purpose  : Systolic processing element supporting weight-stationary (WS) and
//            output-stationary (OS) dataflows. It provides double-buffered
//            weights, registered neighbour forwarding, a one-cycle flush on a
//            mode change and a sticky signed-overflow flag.
// Options  : define PE_DBUF_SATURATE_EN to clamp an overflowing accumulation
//            instead of letting it wrap in two's complement.
// Revision : 1.0 - initial release
// ============================================================================
module pe_dbuf #(
    parameter int ACT_WIDTH    = 16,
    parameter int WGT_WIDTH    = 16,
    parameter int PE_OUT_WIDTH = 40,
    parameter int OP_SIG_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OP_SIG_WIDTH-1:0] operation_signal_in,
    input  logic                    swap_in,
    input  logic                    valid_in,
    input  logic [ACT_WIDTH-1:0]    act_data_in,
    input  logic [WGT_WIDTH-1:0]    wgt_data_in,
    input  logic [PE_OUT_WIDTH-1:0] result_in,
    output logic [ACT_WIDTH-1:0]    act_data_out,
    output logic [WGT_WIDTH-1:0]    wgt_data_out,
    output logic                    valid_out,
    output logic [PE_OUT_WIDTH-1:0] result_out,
    output logic                    overflow_out
);

    localparam int c_prod_w = ACT_WIDTH + WGT_WIDTH;
    localparam logic [PE_OUT_WIDTH-1:0] c_pos_max = {1'b0, {(PE_OUT_WIDTH-1){1'b1}}};
    localparam logic [PE_OUT_WIDTH-1:0] c_neg_min = {1'b1, {(PE_OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_WS       = 2'd0,
        ST_OS_ACC   = 2'd1,
        ST_OS_DRAIN = 2'd2,
        ST_SWITCH   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic w_mode_os;
    logic w_drain;
    logic w_load;

    assign w_mode_os = operation_signal_in[2];
    assign w_drain   = operation_signal_in[1];
    assign w_load    = operation_signal_in[0];

    // Weight banks: r_ptr selects the active bank, the other is the shadow.
    logic                 r_ptr;
    logic [WGT_WIDTH-1:0] r_bank0;
    logic [WGT_WIDTH-1:0] r_bank1;

    logic [ACT_WIDTH-1:0]    r_act;
    logic [WGT_WIDTH-1:0]    r_wgt;
    logic                    r_valid;
    logic [PE_OUT_WIDTH-1:0] r_result;
    logic                    r_ovf;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_WS;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state. A mode mismatch always inserts exactly one ST_SWITCH cycle;
    // inside OS the accumulate/drain choice tracks bit1 directly.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_WS: begin
                if (w_mode_os) begin
                    w_state_next = ST_SWITCH;
                end
            end
            ST_OS_ACC, ST_OS_DRAIN: begin
                if (!w_mode_os) begin
                    w_state_next = ST_SWITCH;
                end else if (w_drain) begin
                    w_state_next = ST_OS_DRAIN;
                end else begin
                    w_state_next = ST_OS_ACC;
                end
            end
            ST_SWITCH: begin
                if (!w_mode_os) begin
                    w_state_next = ST_WS;
                end else if (w_drain) begin
                    w_state_next = ST_OS_DRAIN;
                end else begin
                    w_state_next = ST_OS_ACC;
                end
            end
            default: begin
                w_state_next = ST_WS;
            end
        endcase
    end

    // The registers below act on the state being entered at this edge, so the
    // flush cycle shows up on the very edge the mode change is seen and a
    // drain request is honoured on the edge it is presented.
    logic w_ws;
    assign w_ws = (w_state_next == ST_WS);

    logic signed [WGT_WIDTH-1:0]    w_active_wgt;
    logic signed [WGT_WIDTH-1:0]    w_mac_wgt;
    logic signed [c_prod_w-1:0]     w_act_ext;
    logic signed [c_prod_w-1:0]     w_wgt_ext;
    logic signed [c_prod_w-1:0]     w_prod;
    logic signed [PE_OUT_WIDTH-1:0] w_prod_ext;
    logic signed [PE_OUT_WIDTH-1:0] w_addend;
    logic signed [PE_OUT_WIDTH-1:0] w_sum;
    logic [PE_OUT_WIDTH-1:0]        w_mac_res;
    logic                           w_ovf;

    assign w_active_wgt = r_ptr ? $signed(r_bank1) : $signed(r_bank0);
    assign w_mac_wgt    = w_ws ? w_active_wgt : $signed(wgt_data_in);
    assign w_act_ext    = c_prod_w'($signed(act_data_in));
    assign w_wgt_ext    = c_prod_w'(w_mac_wgt);
    assign w_prod       = w_act_ext * w_wgt_ext;
    assign w_prod_ext   = PE_OUT_WIDTH'(w_prod);
    // WS adds onto the incoming partial sum, OS onto the local accumulator.
    assign w_addend     = w_ws ? $signed(result_in) : $signed(r_result);
    assign w_sum        = w_addend + w_prod_ext;
    assign w_ovf        = (w_addend[PE_OUT_WIDTH-1] == w_prod_ext[PE_OUT_WIDTH-1]) &&
                          (w_sum[PE_OUT_WIDTH-1] != w_addend[PE_OUT_WIDTH-1]);

`ifdef PE_DBUF_SATURATE_EN
    // Clamp toward the sign shared by both addends.
    assign w_mac_res = !w_ovf ? w_sum :
                       (w_addend[PE_OUT_WIDTH-1] ? c_neg_min : c_pos_max);
`else
    // Plain two's-complement wrap; the clamp limits stay unused here.
    logic w_unused_limits;
    assign w_unused_limits = ^{c_pos_max, c_neg_min};
    assign w_mac_res = w_sum;
`endif

    // Weight double buffer: loads always target the shadow bank, so a load
    // combined with a swap writes the bank that becomes active.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr   <= 1'b0;
            r_bank0 <= '0;
            r_bank1 <= '0;
        end else if (w_ws) begin
            if (w_load) begin
                if (r_ptr) begin
                    r_bank0 <= wgt_data_in;
                end else begin
                    r_bank1 <= wgt_data_in;
                end
            end
            if (swap_in) begin
                r_ptr <= ~r_ptr;
            end
        end
    end

    // Activation and weight forwarding to the neighbours; frozen while flushing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_act <= '0;
            r_wgt <= '0;
        end else if (w_state_next != ST_SWITCH) begin
            r_act <= act_data_in;
            r_wgt <= wgt_data_in;
        end
    end

    // Accumulator, valid forwarding and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (w_state_next)
                ST_SWITCH: begin
                    r_result <= '0;
                    r_valid  <= 1'b0;
                    r_ovf    <= 1'b0;
                end
                ST_WS: begin
                    r_valid <= valid_in;
                    if (valid_in) begin
                        r_result <= w_mac_res;
                        if (w_ovf) begin
                            r_ovf <= 1'b1;
                        end
                    end else begin
                        r_result <= result_in;
                    end
                end
                ST_OS_ACC: begin
                    r_valid <= valid_in;
                    if (valid_in) begin
                        r_result <= w_mac_res;
                        if (w_ovf) begin
                            r_ovf <= 1'b1;
                        end
                    end
                end
                ST_OS_DRAIN: begin
                    r_valid  <= valid_in;
                    r_result <= result_in;
                end
                default: begin
                    r_valid <= valid_in;
                end
            endcase
        end
    end

    assign act_data_out = r_act;
    assign wgt_data_out = r_wgt;
    assign valid_out    = r_valid;
    assign result_out   = r_result;
    assign overflow_out = r_ovf;

endmodule
`default_nettype wire
